// File: rtl/counter_prescaler_if.sv
// Handshake bundle between a tick-generator controller and counter_prescaler.
// The master drives run requests and the programmed period/burst; the slave returns strobes and status.
interface counter_prescaler_if #(
  parameter int WIDTH   = 8,
  parameter int BURST_W = 4
) ();
  logic               start;
  logic               stop;
  logic               continuous;
  logic [WIDTH-1:0]   period;
  logic [BURST_W-1:0] burst;
  logic               tick;
  logic               load;
  logic               busy;
  logic               done;
  logic [BURST_W-1:0] remaining;

  modport master (
    output start, stop, continuous, period, burst,
    input  tick, load, busy, done, remaining
  );

  modport slave (
    input  start, stop, continuous, period, burst,
    output tick, load, busy, done, remaining
  );
endinterface

// File: rtl/counter_prescaler.sv
// Programmable clock divider that produces tick strobes for a downstream counter enable.
// It runs continuously or for a fixed one-shot burst, and it pulses load once when a run starts.
module counter_prescaler #(
  parameter int WIDTH   = 8,
  parameter int BURST_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  counter_prescaler_if.slave  bus
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [WIDTH-1:0]   DIV_ONE   = WIDTH'(1);
  localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);

  state_t             state;
  logic [WIDTH-1:0]   div;
  logic [WIDTH-1:0]   per;
  logic               mode;
  logic [BURST_W-1:0] rem;
  logic               tick_r;
  logic               load_r;
  logic               done_r;

  // A period of zero is treated as divide-by-one, so the reload value Peff-1 can never underflow.
  function automatic logic [WIDTH-1:0] eff_period(input logic [WIDTH-1:0] p);
    return (p == '0) ? DIV_ONE : p;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      div    <= '0;
      per    <= '0;
      mode   <= 1'b0;
      rem    <= '0;
      tick_r <= 1'b0;
      load_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tick_r <= 1'b0;
          done_r <= 1'b0;
          if (bus.start && !bus.stop && (bus.continuous || bus.burst != '0)) begin
            state  <= RUN;
            per    <= eff_period(bus.period);
            div    <= eff_period(bus.period) - DIV_ONE;
            load_r <= 1'b1;
            mode   <= bus.continuous;
            rem    <= bus.continuous ? '0 : bus.burst;
          end else begin
            load_r <= 1'b0;
          end
        end
        RUN: begin
          load_r <= 1'b0;
          // stop wins over a tick that is due on this same edge
          if (bus.stop) begin
            state  <= IDLE;
            tick_r <= 1'b0;
            done_r <= 1'b0;
            rem    <= '0;
            div    <= '0;
          end else if (div == '0) begin
            tick_r <= 1'b1;
            div    <= per - DIV_ONE;
            done_r <= 1'b0;
            if (!mode) begin
              rem <= rem - BURST_ONE;
              if (rem == BURST_ONE) begin
                state  <= IDLE;
                done_r <= 1'b1;
              end
            end
          end else begin
            tick_r <= 1'b0;
            done_r <= 1'b0;
            div    <= div - DIV_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.tick      = tick_r;
  assign bus.load      = load_r;
  assign bus.done      = done_r;
  assign bus.busy      = (state == RUN);
  assign bus.remaining = rem;

endmodule
